// File: rtl/fht_pkg.sv
// Shared definitions for the FHT sequencing controller.
//   fsm_state_e : controller phase encoding
//   st_num()    : number of butterfly stages for a given bank address width
//   stage_w()   : bit width needed to hold a stage index
package fht_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fsm_state_e;

  function automatic int unsigned st_num(input int unsigned a_bit);
    return a_bit + 2;
  endfunction

  function automatic int unsigned stage_w(input int unsigned a_bit);
    return $clog2(a_bit + 2);
  endfunction

endpackage

// File: rtl/fht_dly_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
//   iCLK    : clock
//   iRESET  : async reset, active-low, clears every stage
//   iD      : WIDTH-bit input
//   oQ      : iD delayed by DEPTH cycles
module fht_dly_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = iD;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) pipe_q <= '0;
    else         pipe_q <= pipe_d;
  end

  assign oQ = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_ctrl.sv
// Sequencer for an in-place Fast Hartley Transform over four data banks.
// Each stage reads every bank address once, then idles BUT_LAT cycles so the
// butterfly pipeline empties before the next stage reads.
//   iCLK, iRESET          : clock, async active-low reset
//   iSTART                : one-cycle transform request (accepted in IDLE only)
//   oBUSY / oDONE         : transform in progress / one-cycle completion pulse
//   oRD_EN, oRD_ADDR      : bank read strobe and address
//   oWR_EN, oWR_ADDR      : bank write strobe and address (read delayed BUT_LAT)
//   oW_ADDR               : twiddle ROM address, aligned with the read
//   oST_ZERO, oST_LAST    : first / last stage flags
//   o2ND_PART_SUBSEC      : output-mixer select, one cycle ahead of the write
//   oSECTOR               : sector index for the input mixers
//   oSTAGE                : current stage number
module fht_ctrl
  import fht_pkg::*;
#(
  parameter int unsigned A_BIT   = 8,
  parameter int unsigned SEC_BIT = 9,
  parameter int unsigned BUT_LAT = 3
) (
  input  logic                      iCLK,
  input  logic                      iRESET,
  input  logic                      iSTART,
  output logic                      oBUSY,
  output logic                      oDONE,
  output logic                      oRD_EN,
  output logic [A_BIT-1:0]          oRD_ADDR,
  output logic                      oWR_EN,
  output logic [A_BIT-1:0]          oWR_ADDR,
  output logic [A_BIT-1:0]          oW_ADDR,
  output logic                      oST_ZERO,
  output logic                      oST_LAST,
  output logic                      o2ND_PART_SUBSEC,
  output logic [SEC_BIT-1:0]        oSECTOR,
  output logic [stage_w(A_BIT)-1:0] oSTAGE
);

  localparam int unsigned ST_NUM = st_num(A_BIT);
  localparam int unsigned SW     = stage_w(A_BIT);
  localparam int unsigned DW     = $clog2(BUT_LAT);
  localparam logic [A_BIT-1:0] ONES = '1;

  fsm_state_e       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [A_BIT-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0]    drn_cnt_q, drn_cnt_d;

  logic             rd_en;
  logic             sel_now;
  logic [A_BIT-1:0] sel_shift;
  logic [A_BIT:0]   wr_dly;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    rd_cnt_d  = rd_cnt_q;
    drn_cnt_d = drn_cnt_q;
    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d  = READ;
          stage_d  = '0;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        if (rd_cnt_q == ONES) begin
          state_d   = DRAIN;
          rd_cnt_d  = '0;
          drn_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_cnt_q == DW'(BUT_LAT - 1)) begin
          drn_cnt_d = '0;
          if (stage_q == SW'(ST_NUM - 1)) begin
            state_d = FIN;
            stage_d = '0;
          end else begin
            state_d = READ;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          drn_cnt_d = drn_cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      rd_cnt_q  <= '0;
      drn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      rd_cnt_q  <= rd_cnt_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // Address generation: rd_cnt is zero outside READ, so sector, twiddle
  // address and mixer select all fall to zero between stages.
  always_comb begin
    rd_en     = (state_q == READ);
    oSECTOR   = SEC_BIT'(rd_cnt_q) >> stage_q;
    oW_ADDR   = '0;
    sel_now   = 1'b0;
    sel_shift = '0;
    if (stage_q <= SW'(A_BIT)) begin
      // low 'stage' bits of the counter, left-justified in the ROM address
      oW_ADDR = (rd_cnt_q & ~(ONES << stage_q)) << (SW'(A_BIT) - stage_q);
    end
    if ((stage_q != '0) && (stage_q <= SW'(A_BIT))) begin
      sel_shift = rd_cnt_q >> (stage_q - 1'b1);
      sel_now   = sel_shift[0];
    end
  end

  fht_dly_line #(
    .WIDTH(A_BIT + 1),
    .DEPTH(BUT_LAT)
  ) u_wr_dly (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .iD    ({rd_en, rd_cnt_q}),
    .oQ    (wr_dly)
  );

  // Mixer select leads the write by one cycle because the butterfly output
  // mixer is itself registered.
  fht_dly_line #(
    .WIDTH(1),
    .DEPTH(BUT_LAT - 1)
  ) u_sel_dly (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .iD    (sel_now),
    .oQ    (o2ND_PART_SUBSEC)
  );

  assign oWR_EN   = wr_dly[A_BIT];
  assign oWR_ADDR = wr_dly[A_BIT-1:0];
  assign oRD_EN   = rd_en;
  assign oRD_ADDR = rd_cnt_q;
  assign oBUSY    = (state_q == READ) || (state_q == DRAIN);
  assign oDONE    = (state_q == FIN);
  assign oST_ZERO = (stage_q == '0);
  assign oST_LAST = (stage_q == SW'(ST_NUM - 1));
  assign oSTAGE   = stage_q;

endmodule

// File: tb/tb_fht_ctrl.sv
// Self-checking bench for fht_ctrl with A_BIT=3, BUT_LAT=3.
module tb_fht_ctrl;

  localparam int AB     = 3;
  localparam int LAT    = 3;
  localparam int NRD    = 8;
  localparam int STN    = 5;
  localparam int SPAN   = NRD + LAT;
  localparam int DONE_C = STN * SPAN + 1;

  logic       iCLK = 1'b0;
  logic       iRESET;
  logic       iSTART;
  logic       oBUSY, oDONE, oRD_EN, oWR_EN, oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;
  logic [2:0] oRD_ADDR, oWR_ADDR, oW_ADDR, oSTAGE;
  logic [8:0] oSECTOR;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] rd_addr;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [2:0] w_addr;
    logic       st_zero;
    logic       st_last;
    logic       sel;
    logic [8:0] sector;
    logic [2:0] stage;
  } obs_t;

  obs_t obs;
  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 iCLK = ~iCLK;

  fht_ctrl #(
    .A_BIT  (AB),
    .SEC_BIT(9),
    .BUT_LAT(LAT)
  ) dut (
    .iCLK            (iCLK),
    .iRESET          (iRESET),
    .iSTART          (iSTART),
    .oBUSY           (oBUSY),
    .oDONE           (oDONE),
    .oRD_EN          (oRD_EN),
    .oRD_ADDR        (oRD_ADDR),
    .oWR_EN          (oWR_EN),
    .oWR_ADDR        (oWR_ADDR),
    .oW_ADDR         (oW_ADDR),
    .oST_ZERO        (oST_ZERO),
    .oST_LAST        (oST_LAST),
    .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
    .oSECTOR         (oSECTOR),
    .oSTAGE          (oSTAGE)
  );

  always_comb obs = {oBUSY, oDONE, oRD_EN, oRD_ADDR, oWR_EN, oWR_ADDR, oW_ADDR,
                     oST_ZERO, oST_LAST, o2ND_PART_SUBSEC, oSECTOR, oSTAGE};

  // Expected outputs c cycles after the cycle in which iSTART was accepted.
  function automatic obs_t exp_at(int c);
    obs_t e;
    int s, p, rc, q;
    e = '0;
    e.st_zero = 1'b1;
    if (c == DONE_C) begin
      e.done = 1'b1;
    end else if (c >= 1 && c < DONE_C) begin
      s  = (c - 1) / SPAN;
      p  = (c - 1) % SPAN;
      rc = (p < NRD) ? p : 0;
      e.busy    = 1'b1;
      e.rd_en   = (p < NRD);
      e.rd_addr = 3'(rc);
      e.sector  = 9'(rc >> s);
      e.w_addr  = (s <= AB) ? 3'((rc % (1 << s)) << (AB - s)) : 3'd0;
      e.wr_en   = (p >= LAT);
      e.wr_addr = (p >= LAT) ? 3'(p - LAT) : 3'd0;
      q = p - (LAT - 1);
      e.sel     = (s >= 1 && s <= AB && q >= 0 && q < NRD) ? 1'((q >> (s - 1)) & 1) : 1'b0;
      e.st_zero = (s == 0);
      e.st_last = (s == STN - 1);
      e.stage   = 3'(s);
    end
    return e;
  endfunction

  task automatic test_reset();
    obs_t e;
    iRESET = 1'b0;
    iSTART = 1'b0;
    #1;
    e = exp_at(0);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_async got %h expected %h", obs, e);
    end
    repeat (2) @(negedge iCLK);
    iRESET = 1'b1;
    @(negedge iCLK);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_idle got %h expected %h", obs, e);
    end
  endtask

  // Full transform; extra iSTART pulses mid-run and on the oDONE cycle must be ignored.
  task automatic test_transform();
    obs_t e;
    sb_q.delete();
    for (int c = 0; c <= DONE_C; c++) sb_q.push_back(exp_at(c));
    for (int c = 0; c <= DONE_C; c++) begin
      @(negedge iCLK);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL transform cycle %0d got %h expected %h", c, obs, e);
      end
      iSTART = (c == 0) || (c == 20) || (c == DONE_C);
    end
  endtask

  // iSTART held one cycle past oDONE starts a new transform immediately.
  task automatic test_back_to_back();
    obs_t e;
    sb_q.delete();
    for (int c = 0; c < 30; c++) sb_q.push_back(exp_at(c));
    for (int c = 0; c < 30; c++) begin
      @(negedge iCLK);
      e = sb_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d got %h expected %h", c, obs, e);
      end
      iSTART = (c == 0);
    end
  endtask

  // Reset mid-stage: outputs clear without a clock edge and stay quiet afterwards.
  task automatic test_reset_abort();
    obs_t e;
    obs_t idle;
    idle = exp_at(0);
    @(negedge iCLK);
    e = exp_at(30);
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL abort_precheck got %h expected %h", obs, e);
    end
    iRESET = 1'b0;
    #1;
    n_checks++;
    if (obs !== idle) begin
      n_fail++;
      $display("FAIL abort_async got %h expected %h", obs, idle);
    end
    repeat (2) @(negedge iCLK);
    iRESET = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge iCLK);
      n_checks++;
      if (obs !== idle) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d got %h expected %h", c, obs, idle);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transform();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fht_ctrl.md
FHT_CTRL -- requirements
Module: fht_ctrl

Interface
REQ-001 A_BIT, default 8: address width of each of the 4 data banks; transform size N = 4*2^A_BIT; stage count ST_NUM = A_BIT+2.
REQ-002 SEC_BIT, default 9: width of oSECTOR; SEC_BIT >= A_BIT.
REQ-003 BUT_LAT, default 3: cycles from bank read to butterfly-block output valid; BUT_LAT >= 2.
REQ-004 iCLK  in  1  clock; all state changes on rising edge.
REQ-005 iRESET  in  1  reset, asynchronous, active-low.
REQ-006 iSTART  in  1  single-cycle transform request.
REQ-007 oBUSY  out  1  high while a transform is in progress.
REQ-008 oDONE  out  1  single-cycle pulse on transform completion.
REQ-009 oRD_EN / oRD_ADDR  out  1 / A_BIT  bank read strobe and address.
REQ-010 oWR_EN / oWR_ADDR  out  1 / A_BIT  bank write strobe and address.
REQ-011 oW_ADDR  out  A_BIT  twiddle ROM address, aligned with oRD_ADDR.
REQ-012 oST_ZERO / oST_LAST  out  1 / 1  first-stage / last-stage flags to butterfly block.
REQ-013 o2ND_PART_SUBSEC  out  1  output-mixer select to butterfly block.
REQ-014 oSECTOR  out  SEC_BIT  sector index to butterfly block input mixers.
REQ-015 oSTAGE  out  ceil(log2(ST_NUM))  current stage number.

Function
REQ-016 FSM states IDLE, READ, DRAIN, FIN; IDLE->READ on iSTART; READ->DRAIN after read of address 2^A_BIT-1; DRAIN->READ (stage+1) after BUT_LAT cycles if stage < ST_NUM-1, else DRAIN->FIN; FIN->IDLE unconditionally after one cycle.
REQ-017 iSTART in any state other than IDLE is ignored.
REQ-018 READ: oRD_EN=1, rd_cnt counts 0..2^A_BIT-1, one per cycle, oRD_ADDR=rd_cnt; first read the cycle after iSTART.
REQ-019 DRAIN: oRD_EN=0, rd_cnt held at 0; guarantees last write of a stage precedes first read of next stage.
REQ-020 oWR_EN and oWR_ADDR equal oRD_EN and oRD_ADDR delayed exactly BUT_LAT cycles; last write of each stage falls in the last DRAIN cycle.
REQ-021 For stage s: oSECTOR = rd_cnt >> s (zero-extended, 0 when s >= A_BIT); oW_ADDR = (rd_cnt mod 2^s) << (A_BIT-s) for s <= A_BIT, else 0.
REQ-022 o2ND_PART_SUBSEC = rd_cnt[s-1] for 1 <= s <= A_BIT, else 0, delayed BUT_LAT-1 cycles (one cycle ahead of write, matching the registered output mixer).
REQ-023 oST_ZERO = (stage==0), oST_LAST = (stage==ST_NUM-1), both held constant through READ and DRAIN of that stage.
REQ-024 oBUSY=1 in READ and DRAIN; oDONE=1 only in FIN; oBUSY=0 in FIN and IDLE.
REQ-025 Per-stage duration 2^A_BIT+BUT_LAT cycles; iSTART at cycle 0 gives oDONE at cycle ST_NUM*(2^A_BIT+BUT_LAT)+1.
REQ-026 Back-to-back: iSTART coincident with oDONE is ignored; iSTART one cycle later is accepted.

Reset
REQ-027 On iRESET low: FSM=IDLE, stage=0, rd_cnt=0, all delay lines cleared; all outputs 0 except oST_ZERO=1.
REQ-028 Reset mid-transform aborts immediately: no oDONE, no further oWR_EN until a new iSTART.

Structure
REQ-029 Package fht_pkg holds the FSM state enumeration and the ST_NUM / stage-width constant functions.
REQ-030 One sub-module fht_dly_line (parametric width and depth shift register, async-reset) used for write strobe/address and mixer-select delays.

Verification
REQ-031 A_BIT=3, BUT_LAT=3, iSTART at cycle 0 -> oRD_EN cycles 1-8, oWR_EN cycles 4-11, stage 1 reads from cycle 12, oDONE only at cycle 56, oBUSY high cycles 1-55.
REQ-032 Same config, stage 2 -> oSECTOR sequence 0,0,0,0,1,1,1,1; oW_ADDR sequence 0,2,4,6,0,2,4,6; o2ND_PART_SUBSEC pattern 0,0,1,1 repeated, leading oWR_EN by one cycle.
REQ-033 Stage 0 -> oST_ZERO=1, oST_LAST=0; stage 4 -> oST_ZERO=0, oST_LAST=1; no read overlaps a write of the previous stage.
REQ-034 iSTART pulsed at cycles 0 and 20 -> second ignored, single oDONE at cycle 56; iSTART at cycle 57 -> new transform, oRD_EN at cycle 58.
REQ-035 iRESET low at cycle 30 for 2 cycles -> all outputs at reset values asynchronously, no oDONE, no oWR_EN until next iSTART.
